fifo_read_logic: RTL and testbench

//  Read-side pointer/flag logic for the dual-clock FIFO: consumes the Gray write pointer from the write domain
//  and synchronises it. Computes empty, drives the RAM read address/enable, and publishes its own Gray read pointer.

---
 rtl/fifo_read_logic.sv | 115 +++++++++++
 tb/tb_fifo_read_logic.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_logic.sv
// Read side of a dual-clock FIFO: synchronises the Gray write pointer, tracks the read pointer,
// and fronts the synchronous RAM with a 2-entry first-word-fall-through output stage.
module fifo_read_logic #(
    parameter int DEPTH         = 32,
    parameter int ADDR_WIDTH_IN = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int SYNC_STAGES   = 2,
    localparam int LOG2_DEPTH   = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH_IN:0]  wrptr_in,
    output logic [LOG2_DEPTH:0]     rdptr_out,
    output logic [LOG2_DEPTH-1:0]   rdaddr_out,
    output logic                    rden_out,
    input  logic [DATA_WIDTH-1:0]   rddata_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic                    empty_out
);
    localparam int PW = LOG2_DEPTH + 1;
    localparam int WW = ADDR_WIDTH_IN + 1;

    logic [WW-1:0]         sync_reg [SYNC_STAGES];
    logic [WW-1:0]         wr_gray_s;
    logic [WW-1:0]         wr_bin;
    logic [PW-1:0]         wr_bin_scaled;
    logic [PW-1:0]         rd_bin_reg;
    logic [PW-1:0]         rd_bin_next;
    logic [PW-1:0]         rdptr_reg;
    logic [DATA_WIDTH-1:0] entry_reg [2];
    logic [1:0]            held_reg;
    logic [1:0]            held_next;
    logic [1:0]            slot;
    logic [2:0]            occupancy;
    logic                  inflight_reg;
    logic                  pop;
    logic                  empty;

    // The raw write pointer is only ever seen by the first synchroniser flop.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= '0;
                    else     sync_reg[gi] <= wrptr_in;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= '0;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign wr_gray_s = sync_reg[SYNC_STAGES-1];

    generate
        for (genvar gi = 0; gi < WW; gi++) begin : g_g2b
            assign wr_bin[gi] = ^(wr_gray_s >> gi);
        end

        // Bring the write-side pointer onto the read side's pointer scale.
        if (WW > PW) begin : g_shr
            assign wr_bin_scaled = wr_bin[WW-1 -: PW];
        end else if (WW == PW) begin : g_same
            assign wr_bin_scaled = wr_bin;
        end else begin : g_shl
            assign wr_bin_scaled = {wr_bin, {(PW-WW){1'b0}}};
        end
    endgenerate

    // Full-width compare: a full wrap (MSB differs) means the RAM holds DEPTH words.
    assign empty     = (rd_bin_reg == wr_bin_scaled);
    assign empty_out = empty;

    assign valid_out  = (held_reg != 2'd0);
    assign pop        = valid_out & ready_in;
    assign data_out   = entry_reg[0];
    assign occupancy  = {1'b0, held_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign rden_out   = !empty && !rst && (occupancy < 3'd2);
    assign rdaddr_out = rd_bin_reg[LOG2_DEPTH-1:0];
    assign rdptr_out  = rdptr_reg;

    assign rd_bin_next = rd_bin_reg + {{(PW-1){1'b0}}, 1'b1};
    assign held_next   = held_reg + {1'b0, inflight_reg} - {1'b0, pop};
    // The arriving word lands behind whatever survives this cycle's pop.
    assign slot        = held_reg - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bin_reg   <= '0;
            rdptr_reg    <= '0;
            held_reg     <= 2'd0;
            inflight_reg <= 1'b0;
            entry_reg[0] <= '0;
            entry_reg[1] <= '0;
        end else begin
            if (rden_out) begin
                rd_bin_reg <= rd_bin_next;
                rdptr_reg  <= rd_bin_next ^ (rd_bin_next >> 1);
            end
            if (pop) begin
                entry_reg[0] <= entry_reg[1];
            end
            if (inflight_reg) begin
                entry_reg[slot[0]] <= rddata_in;
            end
            held_reg     <= held_next;
            inflight_reg <= rden_out;
        end
    end
endmodule

// File: tb/tb_fifo_read_logic.sv
// Bench for fifo_read_logic: a behavioural write side, RAM and word queue drive two instances
// (matched and double-width write pointer) and check ordering, latency, flags and reset.
module tb_fifo_read_logic;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [5:0]  wrptr;
    logic [5:0]  rdptr;
    logic [4:0]  rdaddr;
    logic        rden;
    logic [31:0] rddata = '0;
    logic [31:0] dout;
    logic        valid;
    logic        ready;
    logic        empty;

    logic [6:0]  wrptr2;
    logic [5:0]  rdptr2;
    logic [4:0]  rdaddr2;
    logic        rden2;
    logic [31:0] rddata2 = '0;
    logic [31:0] dout2;
    logic        valid2;
    logic        ready2;
    logic        empty2;

    fifo_read_logic #(.DEPTH(32), .ADDR_WIDTH_IN(5), .DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .wrptr_in(wrptr), .rdptr_out(rdptr), .rdaddr_out(rdaddr),
        .rden_out(rden), .rddata_in(rddata), .data_out(dout), .valid_out(valid),
        .ready_in(ready), .empty_out(empty)
    );

    fifo_read_logic #(.DEPTH(32), .ADDR_WIDTH_IN(6), .DATA_WIDTH(32), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .wrptr_in(wrptr2), .rdptr_out(rdptr2), .rdaddr_out(rdaddr2),
        .rden_out(rden2), .rddata_in(rddata2), .data_out(dout2), .valid_out(valid2),
        .ready_in(ready2), .empty_out(empty2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] gray6(input int v);
        logic [5:0] b;
        b = v[5:0];
        return b ^ (b >> 1);
    endfunction

    function automatic logic [6:0] gray7(input int v);
        logic [6:0] b;
        b = v[6:0];
        return b ^ (b >> 1);
    endfunction

    function automatic int gray2bin6(input logic [5:0] g);
        logic [5:0] b;
        b[5] = g[5];
        for (int i = 4; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return int'(b);
    endfunction

    // Behavioural model state: RAM contents, words written, words fetched, expected pop order.
    logic [31:0] ram [32];
    logic [31:0] exp_q [$];
    logic [31:0] exp_word;
    logic [31:0] stall_data;
    logic        stall_prev = 1'b0;
    logic        saw_wrap = 1'b0;
    logic [4:0]  last_addr = '0;
    int wcount = 0;
    int fetched = 0;
    int rden_cnt = 0;
    int rden_run = 0;
    int max_rden_run = 0;
    int valid_run = 0;
    int max_valid_run = 0;
    int pops = 0;
    int pops2 = 0;

    always @(posedge clk) begin
        if (rden)  rddata  <= ram[rdaddr];
        if (rden2) rddata2 <= 32'h0000_A000 + {27'b0, rdaddr2};
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev) begin
                check("hold_valid", valid, 1);
                check("hold_data", dout, stall_data);
            end
            if (valid && ready) begin
                check("pop_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_word = exp_q.pop_front();
                    check("pop_data", dout, exp_word);
                    $display("pop   #%0d data=%08h", pops, dout);
                end
                pops++;
            end
            if (!empty) check("empty_pessimistic", wcount > fetched, 1);
            if (rden) begin
                if (rdaddr == 5'd0 && last_addr == 5'd31) saw_wrap = 1'b1;
                last_addr = rdaddr;
                fetched++;
                rden_cnt++;
                rden_run++;
                if (rden_run > max_rden_run) max_rden_run = rden_run;
            end else begin
                rden_run = 0;
            end
            if (valid) begin
                valid_run++;
                if (valid_run > max_valid_run) max_valid_run = valid_run;
            end else begin
                valid_run = 0;
            end
            stall_prev = valid && !ready;
            stall_data = dout;
            if (valid2 && ready2) begin
                check("p2_data", dout2, 32'h0000_A000 + 32'(pops2 % 32));
                $display("pop2  #%0d data=%08h", pops2, dout2);
                pops2++;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_model();
        wrptr = '0; wrptr2 = '0; ready = 1'b0; ready2 = 1'b0;
        wcount = 0; fetched = 0; rden_cnt = 0; pops = 0; pops2 = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        step(3);
        rst = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        ram[wcount % 32] = d;
        exp_q.push_back(d);
        wcount++;
        wrptr = gray6(wcount % 64);
    endtask

    task automatic push_bulk(input int n);
        for (int i = 0; i < n; i++) begin
            ram[wcount % 32] = $urandom;
            exp_q.push_back(ram[wcount % 32]);
            wcount++;
        end
        wrptr = gray6(wcount % 64);
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        while (exp_q.size() > 0 && c < 500) begin
            step(1);
            c++;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    logic [31:0] word0;
    int pushed;
    int used;
    logic done;

    initial begin
        rst = 1'b1;
        clear_model();
        for (int i = 0; i < 32; i++) ram[i] = '0;

        // Reset state holds while nothing is written.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            check("rst_valid", valid, 0);
            check("rst_empty", empty, 1);
            check("rst_rdptr", rdptr, 0);
            check("rst_rden", rden, 0);
            check("rst_data", dout, 0);
            step(1);
        end

        // First word latency: write at cycle 0, fetch at cycle 2, visible at cycle 4.
        word0 = $urandom;
        push(word0);
        step(1);
        check("lat_rden_c1", rden, 0);
        step(1);
        check("lat_rden_c2", rden, 1);
        check("lat_addr_c2", rdaddr, 0);
        step(1);
        check("lat_rden_c3", rden, 0);
        check("lat_valid_c3", valid, 0);
        step(1);
        check("lat_valid_c4", valid, 1);
        check("lat_data_c4", dout, word0);
        check("lat_rdptr_c4", rdptr, 1);
        ready = 1'b1;
        drain("lat");
        step(2);
        check("lat_empty_after", empty, 1);

        // 32 words at once, full-wrap compare must read as non-empty.
        do_reset();
        push_bulk(32);
        ready = 1'b1;
        max_rden_run = 0;
        max_valid_run = 0;
        drain("burst");
        step(3);
        check("burst_rden_run", max_rden_run, 32);
        check("burst_valid_run", max_valid_run, 32);
        check("burst_empty", empty, 1);
        check("burst_rdptr", rdptr, 6'h30);
        check("burst_valid_end", valid, 0);

        // Back-pressure: only two words are fetched while the consumer stalls.
        do_reset();
        push_bulk(5);
        step(12);
        check("bp_fetches", rden_cnt, 2);
        check("bp_rden", rden, 0);
        check("bp_valid", valid, 1);
        check("bp_head", dout, exp_q[0]);
        ready = 1'b1;
        drain("bp");
        step(3);
        check("bp_total_fetches", rden_cnt, 5);
        check("bp_empty", empty, 1);
        check("bp_rdptr", rdptr, gray6(5));

        // Random push/pop of 80 words, wrapping the pointers.
        do_reset();
        saw_wrap = 1'b0;
        pushed = 0;
        done = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            ready = ($urandom_range(0, 3) != 0);
            used = (wcount - gray2bin6(rdptr)) & 63;
            if (pushed < 80 && $urandom_range(0, 1) == 1 && used < 32) begin
                push($urandom);
                pushed++;
            end
            step(1);
            done = (pushed == 80) && (exp_q.size() == 0);
        end
        check("rand_done", done, 1);
        ready = 1'b1;
        step(4);
        check("rand_pops", pops, 80);
        check("rand_empty", empty, 1);
        check("rand_rdptr", rdptr, gray6(80));
        check("rand_addr_wrap", saw_wrap, 1);

        // Reset in the middle of streaming drops everything held or in flight.
        do_reset();
        ready = 1'b1;
        push_bulk(20);
        step(8);
        rst = 1'b1;
        step(1);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_rden", rden, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_rdptr", rdptr, 0);
        check("mid_rst_data", dout, 0);
        clear_model();
        ready = 1'b1;
        step(2);
        rst = 1'b0;
        step(4);
        check("post_rst_valid", valid, 0);
        check("post_rst_empty", empty, 1);
        check("post_rst_rden", rden, 0);

        // Wider write pointer is halved: gray(7) means 3 words, gray(8) means 4.
        do_reset();
        ready2 = 1'b1;
        wrptr2 = gray7(7);
        step(15);
        check("w6_pops_3", pops2, 3);
        check("w6_empty_3", empty2, 1);
        check("w6_rdptr_3", rdptr2, gray6(3));
        wrptr2 = gray7(8);
        step(10);
        check("w6_pops_4", pops2, 4);
        check("w6_empty_4", empty2, 1);
        check("w6_rdptr_4", rdptr2, gray6(4));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
